vdp_sprite_hit_list_reader: RTL and testbench



---
 rtl/vdp_sprite_pkg.sv | 65 ++++++
 rtl/vdp_sprite_row_addr.sv | 20 ++
 rtl/vdp_sprite_hit_list_reader.sv | 162 ++++++++++++++++
 tb/tb_vdp_sprite_hit_list_reader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_sprite_pkg.sv
// Shared sprite-pipeline definitions: hit-list entry and attribute layouts, row-address
// constants and reader FSM states. Used by the collision stage, the reader and the blitter.
package vdp_sprite_pkg;

  localparam int HIT_LIST_MAX    = 256;
  localparam int TILE_ROW_STRIDE = 16;

  // Hit-list entry: {width_select, y_intersect[3:0], sprite_id[7:0]}
  localparam int SPRITE_ID_W  = 8;
  localparam int Y_ISECT_W    = 4;
  localparam int HIT_ENTRY_W  = 13;
  localparam int HIT_ID_LSB   = 0;
  localparam int HIT_Y_LSB    = 8;
  localparam int HIT_WSEL_BIT = 12;

  // Attribute word: {flip_x, palette[3:0], tile[9:0], x[10:0]}
  localparam int ATTR_X_W      = 11;
  localparam int ATTR_TILE_W   = 10;
  localparam int ATTR_PAL_W    = 4;
  localparam int ATTR_W        = 26;
  localparam int ATTR_X_LSB    = 0;
  localparam int ATTR_TILE_LSB = 11;
  localparam int ATTR_PAL_LSB  = 21;
  localparam int ATTR_FLIP_BIT = 25;

  localparam int ROW_ADDR_W = ATTR_TILE_W + 3;

  typedef struct packed {
    logic                   width_select;
    logic [Y_ISECT_W-1:0]   y_intersect;
    logic [SPRITE_ID_W-1:0] sprite_id;
  } hit_entry_t;

  typedef struct packed {
    logic                   flip_x;
    logic [ATTR_PAL_W-1:0]  palette;
    logic [ATTR_TILE_W-1:0] tile;
    logic [ATTR_X_W-1:0]    x;
  } sprite_attr_t;

  typedef enum logic [1:0] {
    IDLE,
    READ_HIT,
    READ_ATTR,
    EMIT
  } reader_state_t;

  function automatic hit_entry_t unpack_hit(input logic [HIT_ENTRY_W-1:0] raw);
    hit_entry_t e;
    e.width_select = raw[HIT_WSEL_BIT];
    e.y_intersect  = raw[HIT_Y_LSB +: Y_ISECT_W];
    e.sprite_id    = raw[HIT_ID_LSB +: SPRITE_ID_W];
    return e;
  endfunction

  function automatic sprite_attr_t unpack_attr(input logic [ATTR_W-1:0] raw);
    sprite_attr_t a;
    a.flip_x  = raw[ATTR_FLIP_BIT];
    a.palette = raw[ATTR_PAL_LSB +: ATTR_PAL_W];
    a.tile    = raw[ATTR_TILE_LSB +: ATTR_TILE_W];
    a.x       = raw[ATTR_X_LSB +: ATTR_X_W];
    return a;
  endfunction

endpackage

// File: rtl/vdp_sprite_row_addr.sv
// VRAM row address of a sprite's intersecting tile row: lower half of a 16-tall sprite
// lives one tile row (16 tiles) further on, wrapping within the 1024-tile space. Combinational.
module vdp_sprite_row_addr
  import vdp_sprite_pkg::*;
(
  input  logic [ATTR_TILE_W-1:0] tile,
  input  logic [Y_ISECT_W-1:0]   y_intersect,
  output logic [ROW_ADDR_W-1:0]  row_addr
);

  localparam logic [ATTR_TILE_W-1:0] STRIDE = ATTR_TILE_W'(TILE_ROW_STRIDE);

  logic [ATTR_TILE_W-1:0] row_tile;

  always_comb begin
    row_tile = tile + (y_intersect[Y_ISECT_W-1] ? STRIDE : '0);
    row_addr = {row_tile, y_intersect[Y_ISECT_W-2:0]};
  end

endmodule

// File: rtl/vdp_sprite_hit_list_reader.sv
// Walks the line's sprite hit list and emits one render job per hit; first job 3 cycles after
// start, 1 job / 3 cycles peak. Job held stable until job_ready; a new start aborts the walk.
module vdp_sprite_hit_list_reader
  import vdp_sprite_pkg::*;
#(
  parameter int HIT_LIST_DEPTH = HIT_LIST_MAX,
  localparam int IDX_W = $clog2(HIT_LIST_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8:0]             hit_count,
  output logic [IDX_W-1:0]       hit_read_addr,
  input  logic [HIT_ENTRY_W-1:0] hit_read_data,
  output logic [SPRITE_ID_W-1:0] attr_read_id,
  input  logic [ATTR_W-1:0]      attr_read_data,
  output logic                   job_valid,
  input  logic                   job_ready,
  output logic [ATTR_X_W-1:0]    job_x,
  output logic [ROW_ADDR_W-1:0]  job_row_addr,
  output logic [ATTR_PAL_W-1:0]  job_palette,
  output logic                   job_flip_x,
  output logic                   job_width_select,
  output logic                   busy,
  output logic                   done
);

  localparam logic [8:0] CNT_MAX = 9'(HIT_LIST_DEPTH);

  reader_state_t          state_q, state_d;
  logic [IDX_W-1:0]       index_q, index_d;
  logic [8:0]             count_q, count_d;
  hit_entry_t             entry_q, entry_d;
  logic                   job_valid_q, job_valid_d;
  logic [ATTR_X_W-1:0]    job_x_q, job_x_d;
  logic [ROW_ADDR_W-1:0]  job_row_addr_q, job_row_addr_d;
  logic [ATTR_PAL_W-1:0]  job_palette_q, job_palette_d;
  logic                   job_flip_x_q, job_flip_x_d;
  logic                   job_wsel_q, job_wsel_d;
  logic                   done_zero_q, done_zero_d;

  hit_entry_t             hit_in;
  sprite_attr_t           attr_in;
  logic [ROW_ADDR_W-1:0]  row_addr;
  logic [8:0]             count_clamped;
  logic                   last_entry;
  logic                   done_final;

  assign hit_in  = unpack_hit(hit_read_data);
  assign attr_in = unpack_attr(attr_read_data);

  vdp_sprite_row_addr u_row_addr (
    .tile        (attr_in.tile),
    .y_intersect (entry_q.y_intersect),
    .row_addr    (row_addr)
  );

  assign count_clamped = (hit_count > CNT_MAX) ? CNT_MAX : hit_count;
  assign last_entry    = (9'(index_q) + 9'd1) == count_q;

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    count_d        = count_q;
    entry_d        = entry_q;
    job_valid_d    = job_valid_q;
    job_x_d        = job_x_q;
    job_row_addr_d = job_row_addr_q;
    job_palette_d  = job_palette_q;
    job_flip_x_d   = job_flip_x_q;
    job_wsel_d     = job_wsel_q;
    done_zero_d    = 1'b0;
    done_final     = 1'b0;
    hit_read_addr  = index_q;

    case (state_q)
      READ_HIT: begin
        entry_d = hit_in;
        state_d = READ_ATTR;
      end
      READ_ATTR: begin
        job_x_d        = attr_in.x;
        job_row_addr_d = row_addr;
        job_palette_d  = attr_in.palette;
        job_flip_x_d   = attr_in.flip_x;
        job_wsel_d     = entry_q.width_select;
        job_valid_d    = 1'b1;
        state_d        = EMIT;
      end
      EMIT: begin
        if (job_ready) begin
          job_valid_d = 1'b0;
          if (last_entry) begin
            done_final = 1'b1;
            index_d    = '0;
            state_d    = IDLE;
          end else begin
            // The RAM read for the next entry is issued in the accept cycle.
            index_d       = index_q + IDX_W'(1);
            hit_read_addr = index_q + IDX_W'(1);
            state_d       = READ_HIT;
          end
        end
      end
      default: ;
    endcase

    // start in any state restarts from entry 0; an aborted walk never reports done.
    if (start) begin
      job_valid_d   = 1'b0;
      done_final    = 1'b0;
      index_d       = '0;
      hit_read_addr = '0;
      count_d       = count_clamped;
      if (count_clamped == 9'd0) begin
        done_zero_d = 1'b1;
        state_d     = IDLE;
      end else begin
        state_d = READ_HIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      index_q        <= '0;
      count_q        <= '0;
      entry_q        <= '0;
      job_valid_q    <= 1'b0;
      job_x_q        <= '0;
      job_row_addr_q <= '0;
      job_palette_q  <= '0;
      job_flip_x_q   <= 1'b0;
      job_wsel_q     <= 1'b0;
      done_zero_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      count_q        <= count_d;
      entry_q        <= entry_d;
      job_valid_q    <= job_valid_d;
      job_x_q        <= job_x_d;
      job_row_addr_q <= job_row_addr_d;
      job_palette_q  <= job_palette_d;
      job_flip_x_q   <= job_flip_x_d;
      job_wsel_q     <= job_wsel_d;
      done_zero_q    <= done_zero_d;
    end
  end

  assign attr_read_id     = (state_q == READ_HIT) ? hit_in.sprite_id : entry_q.sprite_id;
  assign job_valid        = job_valid_q;
  assign job_x            = job_x_q;
  assign job_row_addr     = job_row_addr_q;
  assign job_palette      = job_palette_q;
  assign job_flip_x       = job_flip_x_q;
  assign job_width_select = job_wsel_q;
  assign busy             = (state_q != IDLE);
  assign done             = done_final | done_zero_q;

endmodule

// File: tb/tb_vdp_sprite_hit_list_reader.sv
// Scoreboard bench for the sprite hit-list reader: driver queues hand-computed jobs,
// a monitor pops and compares them on every job handshake.
module tb_vdp_sprite_hit_list_reader;

  typedef struct {
    logic [10:0] x;
    logic [12:0] addr;
    logic [3:0]  pal;
    logic        flip;
    logic        wsel;
    logic        last;
    int          cyc;
  } job_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  hit_count = '0;
  logic [7:0]  hit_read_addr;
  logic [12:0] hit_read_data = '0;
  logic [7:0]  attr_read_id;
  logic [25:0] attr_read_data = '0;
  logic        job_valid;
  logic        job_ready = 1'b0;
  logic [10:0] job_x;
  logic [12:0] job_row_addr;
  logic [3:0]  job_palette;
  logic        job_flip_x;
  logic        job_width_select;
  logic        busy;
  logic        done;

  logic [12:0] hit_mem [256];
  logic [25:0] attr_mem [256];

  job_t sb[$];
  job_t exp_tab [3];
  job_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_seen = 0;
  int   start_cyc = 0;

  vdp_sprite_hit_list_reader #(.HIT_LIST_DEPTH(256)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .hit_count        (hit_count),
    .hit_read_addr    (hit_read_addr),
    .hit_read_data    (hit_read_data),
    .attr_read_id     (attr_read_id),
    .attr_read_data   (attr_read_data),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_x            (job_x),
    .job_row_addr     (job_row_addr),
    .job_palette      (job_palette),
    .job_flip_x       (job_flip_x),
    .job_width_select (job_width_select),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    hit_read_data  <= hit_mem[hit_read_addr];
    attr_read_data <= attr_mem[attr_read_id];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic job_t mkjob(input logic [10:0] x, input logic [12:0] addr,
                                 input logic [3:0] pal, input logic flip, input logic wsel);
    job_t j;
    j.x = x; j.addr = addr; j.pal = pal; j.flip = flip; j.wsel = wsel;
    j.last = 1'b0; j.cyc = -1;
    return j;
  endfunction

  // Independent arithmetic model of a job for bulk tests.
  function automatic job_t model_job(input int i);
    logic [12:0] h;
    logic [25:0] a;
    int id, y, tile, rt;
    h    = hit_mem[i];
    id   = int'(h[7:0]);
    y    = int'(h[11:8]);
    a    = attr_mem[id];
    tile = int'(a[20:11]);
    rt   = (tile + ((y >= 8) ? 16 : 0)) % 1024;
    return mkjob(a[10:0], 13'(rt * 8 + (y % 8)), a[24:21], a[25], h[12]);
  endfunction

  // Monitor: every accepted job must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) done_seen++;
      if (job_valid && job_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_job: got job x=%0d addr=%0d, expected no job", job_x, job_row_addr);
        end else begin
          mon_e = sb.pop_front();
          check("job_x", 32'(job_x), 32'(mon_e.x));
          check("job_row_addr", 32'(job_row_addr), 32'(mon_e.addr));
          check("job_palette", 32'(job_palette), 32'(mon_e.pal));
          check("job_flip_x", 32'(job_flip_x), 32'(mon_e.flip));
          check("job_width_select", 32'(job_width_select), 32'(mon_e.wsel));
          check("done_with_last", 32'(done), 32'(mon_e.last));
          if (mon_e.cyc >= 0) check("job_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  task automatic do_start(input logic [8:0] cnt);
    @(posedge clk) #1;
    start     = 1'b1;
    hit_count = cnt;
    start_cyc = cyc;
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!job_valid && n < budget);
    check("wait_job_valid", 32'(job_valid), 32'd1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_job_valid"}, 32'(job_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_hit_read_addr"}, 32'(hit_read_addr), 32'd0);
    check({tag, "_attr_read_id"}, 32'(attr_read_id), 32'd0);
    check({tag, "_job_fields"},
          32'({job_x, job_row_addr, job_palette, job_flip_x, job_width_select}), 32'd0);
  endtask

  task automatic run_bulk(input logic [8:0] cnt, input int n_jobs, input string name);
    job_t j;
    job_ready = 1'b1;
    done_seen = 0;
    do_start(cnt);
    for (int i = 0; i < n_jobs; i++) begin
      j = model_job(i);
      j.last = (i == n_jobs - 1);
      j.cyc  = start_cyc + 3 * (i + 1);
      sb.push_back(j);
    end
    wait_drain(2000, {name, "_drain"});
    check({name, "_done_count"}, 32'(done_seen), 32'd1);
  endtask

  initial begin
    job_t j;
    for (int i = 0; i < 256; i++) begin
      hit_mem[i]  = '0;
      attr_mem[i] = '0;
    end
    // Hand-computed entries: row_addr = row_tile*8 + y[2:0].
    hit_mem[0] = {1'b0, 4'd3, 8'd5};     attr_mem[5]   = {1'b1, 4'd7, 10'd100, 11'd200};
    hit_mem[1] = {1'b1, 4'd9, 8'd17};    attr_mem[17]  = {1'b0, 4'd2, 10'd1020, 11'd2047};
    hit_mem[2] = {1'b0, 4'd15, 8'd200};  attr_mem[200] = {1'b1, 4'd15, 10'd500, 11'd0};
    hit_mem[3] = {1'b1, 4'd0, 8'd9};     attr_mem[9]   = {1'b0, 4'd1, 10'd1, 11'd1};
    hit_mem[4] = {1'b1, 4'd1, 8'd10};    attr_mem[10]  = {1'b0, 4'd1, 10'd2, 11'd2};
    exp_tab[0] = mkjob(11'd200, 13'd803, 4'd7, 1'b1, 1'b0);   // tile 100, y 3
    exp_tab[1] = mkjob(11'd2047, 13'd97, 4'd2, 1'b0, 1'b1);   // tile 1020+16 wraps to 12, y 9
    exp_tab[2] = mkjob(11'd0, 13'd4135, 4'd15, 1'b1, 1'b0);   // tile 500+16=516, y 15

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk) #1 reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Empty list: done one cycle after start, nothing else moves
    done_seen = 0;
    do_start(9'd0);
    @(negedge clk);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_job_valid", 32'(job_valid), 32'd0);
    check("zero_hit_read_addr", 32'(hit_read_addr), 32'd0);
    @(negedge clk);
    check("zero_done_pulse", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("zero_done_count", 32'(done_seen), 32'd1);
    check("zero_job_valid_late", 32'(job_valid), 32'd0);

    // Three entries, ready held high: jobs at cycles 3, 6, 9
    job_ready = 1'b1;
    done_seen = 0;
    do_start(9'd3);
    check("walk_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      j = exp_tab[i];
      j.last = (i == 2);
      j.cyc  = start_cyc + 3 * (i + 1);
      sb.push_back(j);
    end
    wait_drain(50, "walk3_drain");
    check("walk3_done_count", 32'(done_seen), 32'd1);

    // Blitter stall: fields must stay put for 5 cycles
    job_ready = 1'b0;
    done_seen = 0;
    do_start(9'd2);
    j = exp_tab[0]; sb.push_back(j);
    j = exp_tab[1]; j.last = 1'b1; sb.push_back(j);
    wait_valid(20);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(job_valid), 32'd1);
      check("stall_x", 32'(job_x), 32'(exp_tab[0].x));
      check("stall_row_addr", 32'(job_row_addr), 32'(exp_tab[0].addr));
      check("stall_palette", 32'(job_palette), 32'(exp_tab[0].pal));
      check("stall_flip", 32'(job_flip_x), 32'(exp_tab[0].flip));
      check("stall_wsel", 32'(job_width_select), 32'(exp_tab[0].wsel));
      check("stall_done", 32'(done), 32'd0);
    end
    @(posedge clk) #1 job_ready = 1'b1;
    wait_drain(50, "stall_drain");
    check("stall_done_count", 32'(done_seen), 32'd1);

    // Abort while entry 2 of 5 is pending
    job_ready = 1'b0;
    done_seen = 0;
    do_start(9'd5);
    for (int i = 0; i < 3; i++) begin
      j = exp_tab[i];
      sb.push_back(j);
    end
    for (int k = 0; k < 2; k++) begin
      wait_valid(20);
      @(posedge clk) #1 job_ready = 1'b1;
      @(posedge clk) #1 job_ready = 1'b0;
    end
    wait_valid(20);
    @(posedge clk) #1;
    start     = 1'b1;
    hit_count = 9'd2;
    start_cyc = cyc;
    sb.delete();
    j = exp_tab[0]; j.cyc = start_cyc + 3; sb.push_back(j);
    j = exp_tab[1]; j.cyc = start_cyc + 6; j.last = 1'b1; sb.push_back(j);
    @(posedge clk) #1;
    start     = 1'b0;
    job_ready = 1'b1;
    @(negedge clk);
    check("abort_valid_drop", 32'(job_valid), 32'd0);
    check("abort_no_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd1);
    wait_drain(50, "abort_drain");
    check("abort_done_count", 32'(done_seen), 32'd1);

    // Reset mid-walk: everything back to reset values at once
    job_ready = 1'b0;
    done_seen = 0;
    do_start(9'd3);
    wait_valid(20);
    @(posedge clk) #1 reset_n = 1'b0;
    #1;
    check_all_zero("midwalk_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_midwalk_reset");
    check("midwalk_no_done", 32'(done_seen), 32'd0);
    job_ready = 1'b1;
    do_start(9'd1);
    j = exp_tab[0]; j.last = 1'b1; j.cyc = start_cyc + 3; sb.push_back(j);
    wait_drain(50, "restart_drain");

    // Full list and an over-range count clamped to 256
    for (int i = 0; i < 256; i++) begin
      hit_mem[i]  = {1'(i >> 4), 4'(i * 3), 8'(255 - i)};
      attr_mem[i] = {1'(i), 4'(i >> 2), 10'(i * 4 + 900), 11'(i * 7)};
    end
    run_bulk(9'd256, 256, "full256");
    run_bulk(9'd300, 256, "clamp300");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule
